// File: rtl/pool1_scheduler.sv
// pool1_scheduler
// ----------------------------------------------------------------------------
// Sequencing controller for the pool-1 pairwise max-compare datapath.
// Walks a block of input BRAM words (one compare per word), pulses the
// datapath capture strobe after the BRAM read latency, and produces the output
// BRAM address plus a write qualifier aligned to the datapath result latency.
// Completion is reported through a start/busy/done handshake.
//
// Parameters:
//   ADDR_W   - width of input/output BRAM addresses and of the pair count
//   RD_LAT   - input BRAM read latency (1..4)
//   PIPE_LAT - enable_conv to valid result latency (1..15)
//
// Ports:
//   clk, reset         - clock (rising edge), asynchronous active-high reset
//   start              - one-cycle request, sampled only while idle
//   in_base, out_base  - first input / output word addresses (latched on start)
//   num_pairs          - number of compares (latched on start)
//   abort              - synchronous flush request (ignored while idle)
//   busy, done         - handshake status; done is a one-cycle pulse
//   Input_BRAM_en/addr - input read port
//   enable_conv        - datapath capture strobe
//   Output_BRAM_addr   - output write address
//   out_wr_en          - write qualifier (ANDed with datapath we at top level)
//   cycle_count        - busy-cycle counter, present only when the macro
//                        POOL1_SCHED_PERF_EN is defined
// ----------------------------------------------------------------------------
module pool1_scheduler #(
  parameter int ADDR_W   = 10,
  parameter int RD_LAT   = 2,
  parameter int PIPE_LAT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  input  logic [ADDR_W-1:0] num_pairs,
  input  logic              abort,
`ifdef POOL1_SCHED_PERF_EN
  output logic [31:0]       cycle_count,
`endif
  output logic              busy,
  output logic              done,
  output logic              Input_BRAM_en,
  output logic [ADDR_W-1:0] Input_BRAM_addr,
  output logic              enable_conv,
  output logic [ADDR_W-1:0] Output_BRAM_addr,
  output logic              out_wr_en
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
  localparam logic [ADDR_W:0]   ONE_C = (ADDR_W+1)'(1);

  state_t              state_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                en_reg;
  logic [ADDR_W-1:0]   in_addr_reg;
  logic [ADDR_W-1:0]   out_addr_reg;
  logic [ADDR_W-1:0]   remaining_reg;
  logic [ADDR_W:0]     outstanding_reg;
  logic [ADDR_W:0]     outstanding_next;
  logic [RD_LAT-1:0]   rd_line_reg;
  logic [PIPE_LAT-1:0] wr_line_reg;
  logic                abort_hit;
  logic                start_hit;

  // Abort only counts while a run is in flight; it masks the strobes in the
  // same cycle so nothing leaks out while the flush is taking effect.
  assign abort_hit = abort && (state_reg == ISSUE || state_reg == DRAIN);
  assign start_hit = start && (state_reg == IDLE);

  assign busy             = busy_reg;
  assign done             = done_reg;
  assign Input_BRAM_en    = en_reg & ~abort_hit;
  assign Input_BRAM_addr  = in_addr_reg;
  assign enable_conv      = rd_line_reg[RD_LAT-1] & ~abort_hit;
  assign out_wr_en        = wr_line_reg[PIPE_LAT-1] & ~abort_hit;
  assign Output_BRAM_addr = out_addr_reg;

  // Outstanding compares: issued but not yet written back.
  always_comb begin
    outstanding_next = outstanding_reg;
    if (Input_BRAM_en) outstanding_next = outstanding_next + ONE_C;
    if (out_wr_en)     outstanding_next = outstanding_next - ONE_C;
  end

  // Read-enable delay line: enable_conv is the read enable RD_LAT cycles late.
  generate
    if (RD_LAT == 1) begin : g_rd1
      always_ff @(posedge clk or posedge reset) begin
        if (reset)          rd_line_reg <= '0;
        else if (abort_hit) rd_line_reg <= '0;
        else                rd_line_reg <= en_reg;
      end
    end else begin : g_rdn
      always_ff @(posedge clk or posedge reset) begin
        if (reset)          rd_line_reg <= '0;
        else if (abort_hit) rd_line_reg <= '0;
        else                rd_line_reg <= {rd_line_reg[RD_LAT-2:0], en_reg};
      end
    end
  endgenerate

  // Write delay line: out_wr_en is enable_conv PIPE_LAT cycles late.
  generate
    if (PIPE_LAT == 1) begin : g_wr1
      always_ff @(posedge clk or posedge reset) begin
        if (reset)          wr_line_reg <= '0;
        else if (abort_hit) wr_line_reg <= '0;
        else                wr_line_reg <= enable_conv;
      end
    end else begin : g_wrn
      always_ff @(posedge clk or posedge reset) begin
        if (reset)          wr_line_reg <= '0;
        else if (abort_hit) wr_line_reg <= '0;
        else                wr_line_reg <= {wr_line_reg[PIPE_LAT-2:0], enable_conv};
      end
    end
  endgenerate

  // Output address advances after each qualified write so every write
  // sees its own address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          out_addr_reg <= '0;
    else if (start_hit) out_addr_reg <= out_base;
    else if (out_wr_en) out_addr_reg <= out_addr_reg + ONE_A;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          outstanding_reg <= '0;
    else if (abort_hit) outstanding_reg <= '0;
    else                outstanding_reg <= outstanding_next;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      en_reg        <= 1'b0;
      in_addr_reg   <= '0;
      remaining_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            in_addr_reg   <= in_base;
            remaining_reg <= num_pairs - ONE_A;
            if (num_pairs == '0) begin
              state_reg <= FINISH;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ISSUE;
              busy_reg  <= 1'b1;
              en_reg    <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (abort_hit) begin
            en_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= FINISH;
          end else if (remaining_reg == '0) begin
            en_reg    <= 1'b0;
            state_reg <= DRAIN;
          end else begin
            in_addr_reg   <= in_addr_reg + ONE_A;
            remaining_reg <= remaining_reg - ONE_A;
          end
        end
        DRAIN: begin
          // Leave on the cycle of the last write so done lands right after it.
          if (abort_hit || outstanding_next == '0) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= FINISH;
          end
        end
        FINISH: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          en_reg    <= 1'b0;
        end
      endcase
    end
  end

`ifdef POOL1_SCHED_PERF_EN
  logic [31:0] cycle_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          cycle_count_reg <= '0;
    else if (start_hit) cycle_count_reg <= '0;
    else if (busy_reg)  cycle_count_reg <= cycle_count_reg + 32'd1;
  end

  assign cycle_count = cycle_count_reg;
`endif

endmodule

// File: tb/tb_pool1_scheduler.sv
// Testbench for pool1_scheduler: directed runs checked every cycle against a
// timing model that computes outputs from run parameters (start cycle, count,
// bases, abort cycle), plus literal pins on done/write cycles and addresses.
module tb_pool1_scheduler;
  localparam int AW = 10;
  localparam int RD = 2;
  localparam int PL = 8;
  localparam int MASK = (1 << AW) - 1;
  localparam int NEVER = 1 << 30;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] in_base = '0;
  logic [AW-1:0] out_base = '0;
  logic [AW-1:0] num_pairs = '0;
  logic          busy, done, Input_BRAM_en, enable_conv, out_wr_en;
  logic [AW-1:0] Input_BRAM_addr, Output_BRAM_addr;
`ifdef POOL1_SCHED_PERF_EN
  logic [31:0]   cycle_count;
`endif

  pool1_scheduler #(.ADDR_W(AW), .RD_LAT(RD), .PIPE_LAT(PL)) dut (
    .clk(clk), .reset(reset), .start(start), .in_base(in_base),
    .out_base(out_base), .num_pairs(num_pairs), .abort(abort),
`ifdef POOL1_SCHED_PERF_EN
    .cycle_count(cycle_count),
`endif
    .busy(busy), .done(done), .Input_BRAM_en(Input_BRAM_en),
    .Input_BRAM_addr(Input_BRAM_addr), .enable_conv(enable_conv),
    .Output_BRAM_addr(Output_BRAM_addr), .out_wr_en(out_wr_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Model state for the current run.
  bit run_valid = 1'b0;
  int run_T, run_N, run_in, run_out, run_A;

  int compared = 0;
  int mismatched = 0;
  int done_seen = 0;
  int last_done = -1;
  int first_wr = -1;
  int first_wr_addr = -1;
  int last_wr_addr = -1;

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : cmp
    int c, ken, kec, kwr, dc;
    bit e_busy, e_done, e_en, e_ec, e_wr;
    c = cyc;
    e_busy = 0; e_done = 0; e_en = 0; e_ec = 0; e_wr = 0; dc = NEVER;
    if (!reset && run_valid) begin
      ken = c - run_T - 1;
      kec = ken - RD;
      kwr = kec - PL;
      if (run_N == 0)                       dc = run_T + 1;
      else if (run_A <= run_T + run_N + RD + PL) dc = run_A + 1;
      else                                  dc = run_T + run_N + RD + PL + 1;
      e_done = (c == dc);
      e_busy = (run_N != 0) && (c >= run_T + 1) && (c < dc);
      e_en = (ken >= 0) && (ken < run_N) && (c < run_A);
      e_ec = (kec >= 0) && (kec < run_N) && (c < run_A);
      e_wr = (kwr >= 0) && (kwr < run_N) && (c < run_A);
    end
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("rd_en", Input_BRAM_en, e_en);
    chk("enable_conv", enable_conv, e_ec);
    chk("out_wr_en", out_wr_en, e_wr);
    if (reset) begin
      chk("rst_in_addr", Input_BRAM_addr, 0);
      chk("rst_out_addr", Output_BRAM_addr, 0);
`ifdef POOL1_SCHED_PERF_EN
      chk("rst_cycle_count", cycle_count, 0);
`endif
    end
    if (e_en) chk("in_addr", Input_BRAM_addr, (run_in + ken) & MASK);
    if (e_wr) chk("out_addr", Output_BRAM_addr, (run_out + kwr) & MASK);
`ifdef POOL1_SCHED_PERF_EN
    if (e_done) chk("cycle_count", cycle_count, dc - run_T - 1);
`endif
    if (done) begin
      done_seen++;
      last_done = c;
    end
    if (out_wr_en) begin
      if (first_wr < 0) begin
        first_wr = c;
        first_wr_addr = Output_BRAM_addr;
      end
      last_wr_addr = Output_BRAM_addr;
    end
  end

  task automatic start_run(input int ib, input int ob, input int n, input bit with_abort);
    @(posedge clk); #1;
    in_base = AW'(ib); out_base = AW'(ob); num_pairs = AW'(n);
    start = 1'b1; abort = with_abort;
    run_valid = 1'b1; run_T = cyc; run_N = n; run_in = ib; run_out = ob;
    run_A = NEVER; done_seen = 0; first_wr = -1; first_wr_addr = -1; last_wr_addr = -1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    $display("reset released at cycle %0d", cyc);

    // Abort while idle is ignored.
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    $display("idle abort issued");

    // Nominal run.
    start_run(32'h010, 32'h200, 4, 1'b0);
    repeat (16) @(posedge clk);
    chk("nom_done_cyc", last_done - run_T, 15);
    chk("nom_first_wr", first_wr - run_T, 11);
    chk("nom_first_addr", first_wr_addr, 32'h200);
    chk("nom_last_addr", last_wr_addr, 32'h203);
    chk("nom_done_cnt", done_seen, 1);
    $display("nominal run: start=%0d done=%0d", run_T, last_done);

    // Zero pairs.
    start_run(5, 6, 0, 1'b0);
    repeat (3) @(posedge clk);
    chk("zero_done_cyc", last_done - run_T, 1);
    chk("zero_no_wr", first_wr, -1);
    $display("zero-pair run: start=%0d done=%0d", run_T, last_done);

    // Address wrap.
    start_run(32'h3FE, 32'h3FF, 3, 1'b0);
    repeat (16) @(posedge clk);
    chk("wrap_done_cyc", last_done - run_T, 14);
    chk("wrap_first_addr", first_wr_addr, 32'h3FF);
    chk("wrap_last_addr", last_wr_addr, 32'h001);
    $display("wrap run: start=%0d done=%0d", run_T, last_done);

    // Abort at cycle 5 of an N=8 run, then a clean run at cycle 7.
    start_run(32'h100, 32'h080, 8, 1'b0);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1; run_A = run_T + 5;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk); #1;
    chk("abort_done_cyc", last_done - run_T, 6);
    chk("abort_no_wr", first_wr, -1);
    $display("abort run: start=%0d done=%0d", run_T, last_done);
    start_run(32'h020, 32'h300, 2, 1'b0);
    chk("post_abort_start", run_T - last_done, 1);
    repeat (14) @(posedge clk);
    chk("post_abort_done", last_done - run_T, 13);
    $display("post-abort run: start=%0d done=%0d", run_T, last_done);

    // Reset at cycle 4 of an N=8 run.
    start_run(0, 0, 8, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1; run_valid = 1'b0; done_seen = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) @(posedge clk);
    chk("rst_no_done", done_seen, 0);
    $display("mid-run reset at cycle 4");
    start_run(32'h010, 32'h200, 4, 1'b0);
    repeat (16) @(posedge clk);
    chk("rerun_done_cyc", last_done - run_T, 15);
    chk("rerun_first_wr", first_wr - run_T, 11);
    $display("rerun after reset: start=%0d done=%0d", run_T, last_done);

    // Start pulsed at cycle 2 of an active run is ignored.
    start_run(32'h040, 32'h140, 4, 1'b0);
    @(posedge clk); #1;
    in_base = AW'(32'h3C0); out_base = AW'(32'h011); num_pairs = AW'(9); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (15) @(posedge clk);
    chk("ign_done_cyc", last_done - run_T, 15);
    chk("ign_done_cnt", done_seen, 1);
    chk("ign_first_addr", first_wr_addr, 32'h140);
`ifdef POOL1_SCHED_PERF_EN
    chk("ign_cycle_count", cycle_count, 14);
`endif
    $display("ignored-start run: start=%0d done=%0d", run_T, last_done);

    // Abort and start together while idle: start wins.
    start_run(32'h200, 32'h000, 2, 1'b1);
    repeat (14) @(posedge clk);
    chk("abst_done_cyc", last_done - run_T, 13);
    chk("abst_first_wr", first_wr - run_T, 11);
    $display("start+abort run: start=%0d done=%0d", run_T, last_done);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pool1_scheduler.md
# pool1_scheduler

Sequencing controller for the pool-1 pairwise max-compare datapath. It walks a block of input BRAM words, each holding two packed 16-bit values, and issues one compare per word by pulsing the datapath's `enable_conv`. It produces the output BRAM address together with a write qualifier aligned to the datapath's fixed result latency, then reports completion to the layer sequencer through a start/done handshake.

## Interface
Parameters:
- `ADDR_W`, 10: width of the input and output BRAM addresses and of the pair count.
- `RD_LAT`, 2: input BRAM read latency, from `Input_BRAM_en` to valid `conv_concat`; legal range 1..4.
- `PIPE_LAT`, 8: cycles from `enable_conv` high to the matching `Output_write_data` being valid; legal range 1..15.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `in_base`  in  ADDR_W  first input word address; latched on accepted `start`.
- `out_base`  in  ADDR_W  first output word address; latched on accepted `start`.
- `num_pairs`  in  ADDR_W  number of compares; latched on accepted `start`.
- `abort`  in  1  synchronous flush request.
- `busy`  out  1  high from the accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last qualified write or an abort.
- `Input_BRAM_en`  out  1  input read enable.
- `Input_BRAM_addr`  out  ADDR_W  input read address.
- `enable_conv`  out  1  datapath capture strobe.
- `Output_BRAM_addr`  out  ADDR_W  output write address.
- `out_wr_en`  out  1  write qualifier; the top level ANDs it with the datapath's `Output_BRAM_we`.

## Operation
- Reset values: every output is 0, the FSM is in IDLE, and both delay lines are cleared.
- FSM states:
  - IDLE: on `start`, latch the bases and count, then go to ISSUE. If `num_pairs`==0, go straight to FINISH instead.
  - ISSUE: one read per cycle. `Input_BRAM_addr` = `in_base`+i for i=0..`num_pairs`-1, with `Input_BRAM_en`=1. After the last issue, go to DRAIN.
  - DRAIN: `Input_BRAM_en`=0. Wait until the outstanding counter reaches 0, then go to FINISH.
  - FINISH: `done`=1 for one cycle, `busy`=0, then return to IDLE.
- Read-enable delay line (depth `RD_LAT`): `enable_conv` equals `Input_BRAM_en` delayed by exactly `RD_LAT` cycles.
- Write delay line (depth `PIPE_LAT`): `out_wr_en` equals `enable_conv` delayed by exactly `PIPE_LAT` cycles.
- `Output_BRAM_addr` starts at `out_base`. It increments by 1 on the cycle after each `out_wr_en`=1, so each write sees its own address.
- Outstanding counter (ADDR_W+1 bits): +1 on each issue, −1 on each `out_wr_en`. An issue and a write in the same cycle leave it unchanged.
- Address arithmetic is modulo 2^ADDR_W; wrap past the top is silent.
- `start` while busy is ignored and has no side effect.
- `abort` in any non-IDLE state:
  - The same cycle: `Input_BRAM_en`=0, both delay lines cleared, outstanding counter = 0.
  - The next cycle: FINISH, so `done` still pulses once.
  - `abort` in IDLE is ignored.
- `abort` and `start` in the same cycle in IDLE: `start` wins.
- Reset asserted mid-run: immediately go to IDLE with all outputs 0 and no `done` pulse.

## Timing
- Accepted `start` at cycle T gives `busy`=1 and the first `Input_BRAM_en` at T+1.
- The k-th compare (k from 0):
  - `Input_BRAM_en` at T+1+k.
  - `enable_conv` at T+1+k+`RD_LAT`.
  - `out_wr_en` at T+1+k+`RD_LAT`+`PIPE_LAT`.
- `done` for N≥1 pairs: at T+N+`RD_LAT`+`PIPE_LAT`+1, i.e. the cycle after the last `out_wr_en`.
- `done` for N=0: at T+1.
- Issue is back-to-back with no bubbles; throughput is one compare per cycle.
- The earliest new `start` is accepted on the cycle after `done`.

## Configuration
- Macro `POOL1_SCHED_PERF_EN`.
- Defined:
  - Adds output `cycle_count` (32 bits).
  - The counter clears on accepted `start` and increments every cycle while `busy`=1.
  - It holds its value after `done` until the next `start`; reset value is 0.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

## Test plan
- Nominal run, with `RD_LAT`=2, `PIPE_LAT`=8, `start` at cycle 0 with `in_base`=0x010, `out_base`=0x200, `num_pairs`=4:
  - `Input_BRAM_addr` reads 0x010..0x013 at cycles 1–4.
  - `enable_conv` is high at cycles 3–6.
  - `out_wr_en` is high at cycles 11–14 with `Output_BRAM_addr` 0x200..0x203.
  - `done` pulses at cycle 15.
- `num_pairs`=0: `done` at cycle 1; `Input_BRAM_en`, `enable_conv` and `out_wr_en` never assert.
- Address wrap with `ADDR_W`=10, `in_base`=0x3FE, `out_base`=0x3FF, N=3:
  - Reads 0x3FE, 0x3FF, 0x000.
  - Writes 0x3FF, 0x000, 0x001.
- Abort with N=8: `abort` at cycle 5 stops issue at once, no `out_wr_en` ever appears, and `done` pulses at cycle 6. A `start` at cycle 7 runs cleanly.
- Reset at cycle 4 of an N=8 run: all outputs 0 in the same cycle, no `done`. A later `start` behaves as in the nominal-run scenario.
- `start` pulsed at cycle 2 during an active run is ignored: the counts are unchanged and there is a single `done`. With `POOL1_SCHED_PERF_EN` defined and N=4, `cycle_count` holds 14 after `done`.
